// File: rtl/vec_pkg.sv
// Shared encodings and helpers for the vector coprocessor slice.
// Lane 0 sits in the most significant slice of a packed vector.
package vec_pkg;

    localparam logic [1:0] OP_VLOAD  = 2'b00;
    localparam logic [1:0] OP_VSTORE = 2'b01;
    localparam logic [1:0] OP_VADD   = 2'b10;
    localparam logic [1:0] OP_VADDS  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_STORE,
        ST_EXEC,
        ST_WB,
        ST_DONE
    } state_t;

    // Top bit index of lane k in a packed vector of `lanes` lanes.
    function automatic int lane_hi(input int k, input int lanes, input int lane_w);
        return (lanes - k) * lane_w - 1;
    endfunction

endpackage

// File: rtl/vec_regfile.sv
// Vector register file: two combinational source reads, one debug read,
// one synchronous write port, cleared asynchronously.
module vec_regfile #(
    parameter  int NVREG = 4,
    parameter  int VEC_W = 32,
    localparam int REG_W = $clog2(NVREG)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] rd1_sel,
    output logic [VEC_W-1:0] rd1_data,
    input  logic [REG_W-1:0] rd2_sel,
    output logic [VEC_W-1:0] rd2_data,
    input  logic [REG_W-1:0] dbg_sel,
    output logic [VEC_W-1:0] dbg_data,
    input  logic             wr_en,
    input  logic [REG_W-1:0] wr_sel,
    input  logic [VEC_W-1:0] wr_data
);

    logic [VEC_W-1:0] vrf_reg [NVREG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NVREG; i++) begin
                vrf_reg[i] <= '0;
            end
        end else if (wr_en) begin
            vrf_reg[wr_sel] <= wr_data;
        end
    end

    assign rd1_data = vrf_reg[rd1_sel];
    assign rd2_data = vrf_reg[rd2_sel];
    assign dbg_data = vrf_reg[dbg_sel];

endmodule

// File: rtl/vector_exec_unit.sv
// Vector coprocessor: one VLOAD/VSTORE/VADD/VADDS per start pulse, driving
// the shared data-memory port while busy.
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int LANE_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int NVREG  = 4,
    localparam int REG_W  = $clog2(NVREG),
    localparam int VEC_W  = LANES * LANE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [REG_W-1:0]  vd,
    input  logic [REG_W-1:0]  vs,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic [REG_W-1:0]  dbg_sel,
    output logic [VEC_W-1:0]  dbg_data
);

    localparam int BEAT_W = $clog2(LANES + 1);
    localparam logic [BEAT_W-1:0] LAST_LOAD  = BEAT_W'(LANES);
    localparam logic [BEAT_W-1:0] LAST_STORE = BEAT_W'(LANES - 1);

    state_t             state_reg;
    logic [1:0]         op_reg;
    logic [REG_W-1:0]   vd_reg;
    logic [REG_W-1:0]   vs_reg;
    logic [ADDR_W-1:0]  base_reg;
    logic [VEC_W-1:0]   x1_reg;
    logic [VEC_W-1:0]   x2_reg;
    logic [VEC_W-1:0]   t_reg;
    logic [BEAT_W-1:0]  beat_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [LANE_W-1:0]  mem_wdata_reg;
    logic               mem_wren_reg;

    logic [VEC_W-1:0]   rd1_data;
    logic [VEC_W-1:0]   rd2_data;
    logic [VEC_W-1:0]   sum_wrap;
    logic [VEC_W-1:0]   sum_sat;

    vec_regfile #(
        .NVREG (NVREG),
        .VEC_W (VEC_W)
    ) u_vrf (
        .clock    (clock),
        .reset    (reset),
        .rd1_sel  (vd_reg),
        .rd1_data (rd1_data),
        .rd2_sel  (vs_reg),
        .rd2_data (rd2_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .wr_en    (state_reg == ST_WB),
        .wr_sel   (vd_reg),
        .wr_data  (t_reg)
    );

    // Each lane gets its own carry chain; the carry-out only feeds saturation.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int HI = lane_hi(gi, LANES, LANE_W);
        logic [LANE_W:0] sum;

        assign sum = {1'b0, x1_reg[HI -: LANE_W]} + {1'b0, x2_reg[HI -: LANE_W]};
        assign sum_wrap[HI -: LANE_W] = sum[LANE_W-1:0];
        assign sum_sat[HI -: LANE_W]  = sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            vd_reg        <= '0;
            vs_reg        <= '0;
            base_reg      <= '0;
            x1_reg        <= '0;
            x2_reg        <= '0;
            t_reg         <= '0;
            beat_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wren_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg    <= op;
                        vd_reg    <= vd;
                        vs_reg    <= vs;
                        base_reg  <= base_addr;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_READ;
                    end
                end

                ST_READ: begin
                    x1_reg   <= rd1_data;
                    x2_reg   <= rd2_data;
                    beat_reg <= '0;
                    case (op_reg)
                        OP_VLOAD: begin
                            mem_addr_reg <= base_reg;
                            state_reg    <= ST_LOAD;
                        end
                        OP_VSTORE: begin
                            // X1 is still being captured, so lane 0 comes straight from the read port.
                            mem_addr_reg  <= base_reg;
                            mem_wdata_reg <= rd1_data[VEC_W-1 -: LANE_W];
                            mem_wren_reg  <= 1'b1;
                            state_reg     <= ST_STORE;
                        end
                        default: state_reg <= ST_EXEC;
                    endcase
                end

                ST_LOAD: begin
                    // Read data trails the address by one beat.
                    if (beat_reg != '0) begin
                        t_reg[lane_hi(int'(beat_reg) - 1, LANES, LANE_W) -: LANE_W] <= mem_rdata;
                    end
                    if (beat_reg < LAST_STORE) begin
                        mem_addr_reg <= base_reg + ADDR_W'(beat_reg + 1'b1);
                    end
                    if (beat_reg == LAST_LOAD) begin
                        beat_reg  <= '0;
                        state_reg <= ST_WB;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end

                ST_STORE: begin
                    if (beat_reg == LAST_STORE) begin
                        mem_wren_reg <= 1'b0;
                        done_reg     <= 1'b1;
                        beat_reg     <= '0;
                        state_reg    <= ST_DONE;
                    end else begin
                        mem_addr_reg  <= base_reg + ADDR_W'(beat_reg + 1'b1);
                        mem_wdata_reg <= x1_reg[lane_hi(int'(beat_reg) + 1, LANES, LANE_W) -: LANE_W];
                        beat_reg      <= beat_reg + 1'b1;
                    end
                end

                ST_EXEC: begin
                    t_reg     <= op_reg[0] ? sum_sat : sum_wrap;
                    state_reg <= ST_WB;
                end

                ST_WB: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    done_reg     <= 1'b0;
                    busy_reg     <= 1'b0;
                    mem_wren_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wren  = mem_wren_reg;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit with a 1-cycle-latency memory model.
// Latency is counted in cycles after the start-accepting edge, sampled on negedges.
module tb_vector_exec_unit;

    localparam logic [1:0] T_VLOAD  = 2'b00;
    localparam logic [1:0] T_VSTORE = 2'b01;
    localparam logic [1:0] T_VADD   = 2'b10;
    localparam logic [1:0] T_VADDS  = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [1:0]  vd = '0;
    logic [1:0]  vs = '0;
    logic [7:0]  base_addr = '0;
    logic        busy;
    logic        done;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_rdata;
    logic [1:0]  dbg_sel = '0;
    logic [31:0] dbg_data;

    logic [7:0]  mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;

    int          checks = 0;
    int          failures = 0;
    int          cyc_cnt = 0;
    int          lat;
    int          accept_cyc;
    bit          wren_seen;
    bit          busy_c1;
    logic [7:0]  wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    vector_exec_unit #(
        .LANES  (4),
        .LANE_W (8),
        .ADDR_W (8),
        .NVREG  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .vd        (vd),
        .vs        (vs),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rdata (mem_rdata),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc_cnt   <= cyc_cnt + 1;
        mem_rdata <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pre_we   = 1'b1;
            pre_addr = a + 8'(i);
            pre_data = w[31 - 8*i -: 8];
        end
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic get_dbg(input logic [1:0] sel, output logic [31:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    // Issues one operation and returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                          input logic [7:0] b);
        @(negedge clock);
        op = o; vd = d; vs = s; base_addr = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        accept_cyc = cyc_cnt;
        lat = 1;
        wren_seen = 1'b0;
        busy_c1 = busy;
        wr_addr_q.delete();
        wr_data_q.delete();
        while (done !== 1'b1 && lat < 64) begin
            if (mem_wren === 1'b1) begin
                wren_seen = 1'b1;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%0b exp=0", mem_wren); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%0h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", mem_wdata); end
        for (int i = 0; i < 4; i++) begin
            get_dbg(2'(i), v);
            checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_vrf%0d got=%08h exp=00000000", i, v); end
        end
        $display("test_reset done");
    endtask

    task automatic test_vload;
        logic [31:0] v;
        preload(8'h10, 32'h11223344);
        run_op(T_VLOAD, 2'd1, 2'd0, 8'h10);
        checks++; if (lat !== 8) begin failures++; $display("FAIL vload_latency got=%0d exp=8", lat); end
        checks++; if (busy_c1 !== 1'b1) begin failures++; $display("FAIL vload_busy got=%0b exp=1", busy_c1); end
        checks++; if (wren_seen !== 1'b0) begin failures++; $display("FAIL vload_wren got=%0b exp=0", wren_seen); end
        get_dbg(2'd1, v);
        checks++; if (v !== 32'h11223344) begin failures++; $display("FAIL vload_v1 got=%08h exp=11223344", v); end
        @(negedge clock);
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL vload_after_done got=%02b exp=00", {busy, done}); end
        $display("test_vload lat=%0d v1=%08h", lat, v);
    endtask

    task automatic test_vstore;
        logic [31:0] v;
        logic [7:0]  exp_a [4];
        logic [7:0]  exp_d [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_op(T_VSTORE, 2'd1, 2'd0, 8'hFE);
        checks++; if (lat !== 6) begin failures++; $display("FAIL vstore_latency got=%0d exp=6", lat); end
        checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL vstore_beats got=%0d exp=4", wr_addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wr_addr_q.size()) begin
                failures++; $display("FAIL vstore_beat%0d got=none exp=%02h@%02h", i, exp_d[i], exp_a[i]);
            end else if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                failures++; $display("FAIL vstore_beat%0d got=%02h@%02h exp=%02h@%02h", i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
            end
        end
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[exp_a[i]] !== exp_d[i]) begin failures++; $display("FAIL vstore_mem%0d got=%02h exp=%02h", i, mem[exp_a[i]], exp_d[i]); end
        end
        checks++; if (mem_addr !== 8'h01) begin failures++; $display("FAIL vstore_addr_hold got=%02h exp=01", mem_addr); end
        get_dbg(2'd1, v);
        checks++; if (v !== 32'h11223344) begin failures++; $display("FAIL vstore_v1 got=%08h exp=11223344", v); end
        $display("test_vstore lat=%0d beats=%0d", lat, wr_addr_q.size());
    endtask

    task automatic test_vadd;
        logic [31:0] v;
        preload(8'h20, 32'hFF017F80);
        run_op(T_VLOAD, 2'd2, 2'd0, 8'h20);
        preload(8'h24, 32'h01018080);
        run_op(T_VLOAD, 2'd3, 2'd0, 8'h24);
        run_op(T_VADD, 2'd2, 2'd3, 8'h00);
        checks++; if (lat !== 4) begin failures++; $display("FAIL vadd_latency got=%0d exp=4", lat); end
        checks++; if (wren_seen !== 1'b0) begin failures++; $display("FAIL vadd_wren got=%0b exp=0", wren_seen); end
        get_dbg(2'd2, v);
        checks++; if (v !== 32'h0002FF00) begin failures++; $display("FAIL vadd_v2 got=%08h exp=0002ff00", v); end
        get_dbg(2'd3, v);
        checks++; if (v !== 32'h01018080) begin failures++; $display("FAIL vadd_v3 got=%08h exp=01018080", v); end
        $display("test_vadd lat=%0d", lat);
    endtask

    task automatic test_vadds;
        logic [31:0] v;
        run_op(T_VLOAD, 2'd2, 2'd0, 8'h20);
        run_op(T_VADDS, 2'd2, 2'd3, 8'h00);
        checks++; if (lat !== 4) begin failures++; $display("FAIL vadds_latency got=%0d exp=4", lat); end
        get_dbg(2'd2, v);
        checks++; if (v !== 32'hFF02FFFF) begin failures++; $display("FAIL vadds_v2 got=%08h exp=ff02ffff", v); end
        $display("test_vadds v2=%08h", v);
    endtask

    task automatic test_same_reg_ignore_start;
        logic [31:0] v;
        int          done_cnt;
        preload(8'h30, 32'h01020304);
        run_op(T_VLOAD, 2'd0, 2'd0, 8'h30);
        @(negedge clock);
        op = T_VADD; vd = 2'd0; vs = 2'd0; base_addr = 8'h00; start = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            start = (c == 2);
            if (c == 2) begin
                op = T_VLOAD; vd = 2'd3; base_addr = 8'h10;
            end
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ignore_start_dones got=%0d exp=1", done_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_start_busy got=%0b exp=0", busy); end
        get_dbg(2'd0, v);
        checks++; if (v !== 32'h02040608) begin failures++; $display("FAIL same_reg_v0 got=%08h exp=02040608", v); end
        get_dbg(2'd3, v);
        checks++; if (v !== 32'h01018080) begin failures++; $display("FAIL ignore_start_v3 got=%08h exp=01018080", v); end
        $display("test_same_reg_ignore_start dones=%0d", done_cnt);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        int          first_acc;
        run_op(T_VADD, 2'd0, 2'd0, 8'h00);
        first_acc = accept_cyc;
        get_dbg(2'd0, v);
        checks++; if (v !== 32'h04080C10) begin failures++; $display("FAIL b2b_first got=%08h exp=04080c10", v); end
        run_op(T_VADD, 2'd0, 2'd0, 8'h00);
        checks++; if (accept_cyc - first_acc !== 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", accept_cyc - first_acc); end
        checks++; if (busy_c1 !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", busy_c1); end
        get_dbg(2'd0, v);
        checks++; if (v !== 32'h08101820) begin failures++; $display("FAIL b2b_second got=%08h exp=08101820", v); end
        $display("test_back_to_back spacing=%0d", accept_cyc - first_acc);
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] v;
        preload(8'h40, 32'hAAAAAAAA);
        @(negedge clock);
        op = T_VSTORE; vd = 2'd1; base_addr = 8'h40; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if ({mem_wren, mem_addr} !== {1'b1, 8'h42}) begin failures++; $display("FAIL midstore_beat2 got=%0b@%02h exp=1@42", mem_wren, mem_addr); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL midstore_wren got=%0b exp=0", mem_wren); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midstore_busy got=%0b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            get_dbg(2'(i), v);
            checks++; if (v !== 32'h0) begin failures++; $display("FAIL midstore_vrf%0d got=%08h exp=00000000", i, v); end
        end
        @(negedge clock);
        reset = 1'b0;
        checks++; if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== 24'h1122AA) begin
            failures++; $display("FAIL midstore_mem got=%06h exp=1122aa", {mem[8'h40], mem[8'h41], mem[8'h42]});
        end
        run_op(T_VLOAD, 2'd1, 2'd0, 8'h10);
        checks++; if (lat !== 8) begin failures++; $display("FAIL reload_latency got=%0d exp=8", lat); end
        get_dbg(2'd1, v);
        checks++; if (v !== 32'h11223344) begin failures++; $display("FAIL reload_v1 got=%08h exp=11223344", v); end
        $display("test_reset_mid_store reload v1=%08h", v);
    endtask

    initial begin
        test_reset();
        test_vload();
        test_vstore();
        test_vadd();
        test_vadds();
        test_same_reg_ignore_start();
        test_back_to_back();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
